// File: rtl/overcooked_pkg.sv
// Shared types and constants for the player scheduler: game states,
// spawn coordinates, coordinate type and the scheduler state encoding.
package overcooked_pkg;

  typedef logic [8:0] coord_t;

  localparam logic [2:0] GS_MENU  = 3'd0;
  localparam logic [2:0] GS_START = 3'd1;
  localparam logic [2:0] GS_PLAY  = 3'd2;

  localparam coord_t SPAWN_X [4] = '{9'd400, 9'd112, 9'd256, 9'd256};
  localparam coord_t SPAWN_Y [4] = '{9'd208, 9'd208, 9'd112, 9'd304};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT
  } sched_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// The pulse appears three clocks after the input rises.
module sync_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = d;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/player_sched.sv
// Per-frame scheduler sharing one player_move engine among up to four slots.
// Define PLAYER_SCHED_TIMEOUT_EN to abandon a slot after TIMEOUT wait cycles.
module player_sched
  import overcooked_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        vsync,
  input  logic [2:0]  game_state,
  input  logic [1:0]  num_players,
  input  logic [15:0] btn,
  output logic        eng_valid,
  input  logic        eng_ready,
  output logic [1:0]  eng_id,
  output logic [8:0]  eng_x,
  output logic [8:0]  eng_y,
  output logic [3:0]  eng_btn,
  input  logic        eng_done,
  input  logic [8:0]  eng_new_x,
  input  logic [8:0]  eng_new_y,
  input  logic [1:0]  eng_new_dir,
  output logic [35:0] player_x,
  output logic [35:0] player_y,
  output logic [7:0]  player_dir,
  output logic        frame_done,
  output logic        overrun,
  output logic        timeout_err
);

`ifdef PLAYER_SCHED_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif
  localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic frame_start;

  sync_edge u_vsync_edge (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (vsync),
    .pulse  (frame_start)
  );

  sched_state_e    state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [1:0]      np_q, np_d;
  coord_t          pos_x_q [4], pos_x_d [4];
  coord_t          pos_y_q [4], pos_y_d [4];
  logic [1:0]      dir_q [4], dir_d [4];
  coord_t          res_x_q, res_x_d, res_y_q, res_y_d;
  logic [1:0]      res_dir_q, res_dir_d;
  logic            eng_valid_q, eng_valid_d;
  logic [1:0]      eng_id_q, eng_id_d;
  coord_t          eng_x_q, eng_x_d, eng_y_q, eng_y_d;
  logic [3:0]      eng_btn_q, eng_btn_d;
  logic            frame_done_q, frame_done_d;
  logic            overrun_q, overrun_d;
  logic            timeout_err_q, timeout_err_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            advance, load_issue, timeout_hit;

  assign timeout_hit = TimeoutEn && (wait_cnt_q == CntW'(TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    np_d          = np_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    dir_d         = dir_q;
    res_x_d       = res_x_q;
    res_y_d       = res_y_q;
    res_dir_d     = res_dir_q;
    eng_valid_d   = eng_valid_q;
    eng_id_d      = eng_id_q;
    eng_x_d       = eng_x_q;
    eng_y_d       = eng_y_q;
    eng_btn_d     = eng_btn_q;
    frame_done_d  = 1'b0;
    overrun_d     = overrun_q | (frame_start && (state_q != S_IDLE));
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = '0;
    advance       = 1'b0;
    load_issue    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start && (game_state == GS_PLAY)) begin
          slot_d     = 2'd0;
          np_d       = num_players;
          state_d    = S_ISSUE;
          load_issue = 1'b1;
        end else if (frame_start && (game_state == GS_START)) begin
          pos_x_d = SPAWN_X;
          pos_y_d = SPAWN_Y;
        end
      end
      S_ISSUE: begin
        // A slot entered with no direction pressed costs exactly this cycle.
        if (!eng_valid_q) begin
          advance = 1'b1;
        end else if (eng_ready) begin
          eng_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          res_x_d   = eng_new_x;
          res_y_d   = eng_new_y;
          res_dir_d = eng_new_dir;
          state_d   = S_COMMIT;
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          advance       = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        pos_x_d[slot_q] = res_x_q;
        pos_y_d[slot_q] = res_y_q;
        dir_d[slot_q]   = res_dir_q;
        advance         = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (slot_q == np_q) begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end else begin
        slot_d     = slot_q + 2'd1;
        state_d    = S_ISSUE;
        load_issue = 1'b1;
      end
    end

    // Request fields are captured on ISSUE entry and held through any stall.
    if (load_issue) begin
      eng_btn_d   = btn[{slot_d, 2'b00} +: 4];
      eng_valid_d = |btn[{slot_d, 2'b00} +: 4];
      eng_id_d    = slot_d;
      eng_x_d     = pos_x_q[slot_d];
      eng_y_d     = pos_y_q[slot_d];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= S_IDLE;
      slot_q        <= 2'd0;
      np_q          <= 2'd0;
      // NOTE: the position registers are a four-entry table but are reset
      // like ordinary flops, because the spawn table is their defined start.
      pos_x_q       <= SPAWN_X;
      pos_y_q       <= SPAWN_Y;
      dir_q         <= '{default: 2'd0};
      res_x_q       <= '0;
      res_y_q       <= '0;
      res_dir_q     <= 2'd0;
      eng_valid_q   <= 1'b0;
      eng_id_q      <= 2'd0;
      eng_x_q       <= '0;
      eng_y_q       <= '0;
      eng_btn_q     <= 4'd0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      np_q          <= np_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      dir_q         <= dir_d;
      res_x_q       <= res_x_d;
      res_y_q       <= res_y_d;
      res_dir_q     <= res_dir_d;
      eng_valid_q   <= eng_valid_d;
      eng_id_q      <= eng_id_d;
      eng_x_q       <= eng_x_d;
      eng_y_q       <= eng_y_d;
      eng_btn_q     <= eng_btn_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign eng_valid   = eng_valid_q;
  assign eng_id      = eng_id_q;
  assign eng_x       = eng_x_q;
  assign eng_y       = eng_y_q;
  assign eng_btn     = eng_btn_q;
  assign player_x    = {pos_x_q[3], pos_x_q[2], pos_x_q[1], pos_x_q[0]};
  assign player_y    = {pos_y_q[3], pos_y_q[2], pos_y_q[1], pos_y_q[0]};
  assign player_dir  = {dir_q[3], dir_q[2], dir_q[1], dir_q[0]};
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_player_sched.sv
// Self-checking bench for player_sched: table of frames plus hand-written
// overrun, timeout (PLAYER_SCHED_TIMEOUT_EN) and reset-mid-pass sequences.
module tb_player_sched;
  import overcooked_pkg::*;

  typedef struct {
    logic [1:0] id;
    coord_t     x;
    coord_t     y;
    logic [3:0] nib;
  } req_t;

  typedef struct {
    logic [2:0]  gs;
    logic [1:0]  np;
    logic [15:0] btn;
    int          stall;
    int          lat;
    bit          drop;
    int          exp_fd;
  } row_t;

  logic        clk, rst, vsync;
  logic [2:0]  game_state;
  logic [1:0]  num_players;
  logic [15:0] btn;
  logic        eng_valid, eng_ready, eng_done;
  logic [1:0]  eng_id, eng_new_dir;
  logic [8:0]  eng_x, eng_y, eng_new_x, eng_new_y;
  logic [3:0]  eng_btn;
  logic [35:0] player_x, player_y;
  logic [7:0]  player_dir;
  logic        frame_done, overrun, timeout_err;

  int checks = 0;
  int failures = 0;

  req_t       sb [$];
  coord_t     exp_x [4];
  coord_t     exp_y [4];
  logic [1:0] exp_d [4];
  int         stall_cycles = 0;
  int         latency = 2;
  bit         never_respond = 1'b0;
  row_t       rows [10];

  player_sched #(.TIMEOUT(16)) dut (
    .clk_in      (clk),
    .reset       (rst),
    .vsync       (vsync),
    .game_state  (game_state),
    .num_players (num_players),
    .btn         (btn),
    .eng_valid   (eng_valid),
    .eng_ready   (eng_ready),
    .eng_id      (eng_id),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_btn     (eng_btn),
    .eng_done    (eng_done),
    .eng_new_x   (eng_new_x),
    .eng_new_y   (eng_new_y),
    .eng_new_dir (eng_new_dir),
    .player_x    (player_x),
    .player_y    (player_y),
    .player_dir  (player_dir),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_positions(input string tag);
    check({tag, "_px"}, player_x, {exp_x[3], exp_x[2], exp_x[1], exp_x[0]});
    check({tag, "_py"}, player_y, {exp_y[3], exp_y[2], exp_y[1], exp_y[0]});
    check({tag, "_pdir"}, player_dir, {exp_d[3], exp_d[2], exp_d[1], exp_d[0]});
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic push_reqs(input logic [1:0] np, input logic [15:0] b);
    req_t r;
    for (int s = 0; s <= int'(np); s++) begin
      if (b[4*s +: 4] != 4'd0) begin
        r.id  = 2'(s);
        r.x   = exp_x[s];
        r.y   = exp_y[s];
        r.nib = b[4*s +: 4];
        sb.push_back(r);
      end
    end
  endtask

  // Bench engine model: stalls, accepts, then returns a result after `latency`.
  initial begin : engine
    req_t       cur;
    logic       busy;
    int         lat_cnt, stall_cnt;
    coord_t     rx, ry;
    logic [1:0] rd;
    busy = 1'b0; lat_cnt = 0; stall_cnt = 0;
    rx = '0; ry = '0; rd = 2'd0;
    eng_ready = 1'b0; eng_done = 1'b0;
    eng_new_x = '0; eng_new_y = '0; eng_new_dir = 2'd0;
    forever begin
      @(negedge clk);
      eng_done  = 1'b0;
      eng_ready = 1'b0;
      if (rst) begin
        busy = 1'b0;
        stall_cnt = 0;
      end else begin
        if (busy) begin
          if (lat_cnt == 0) begin
            eng_done = 1'b1; eng_new_x = rx; eng_new_y = ry; eng_new_dir = rd;
            busy = 1'b0;
          end else begin
            lat_cnt--;
          end
        end
        if (eng_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_req", eng_valid, 1'b0);
          end else begin
            check("req_fields", {eng_id, eng_x, eng_y, eng_btn},
                  {sb[0].id, sb[0].x, sb[0].y, sb[0].nib});
            if (stall_cnt < stall_cycles) begin
              stall_cnt++;
            end else begin
              cur = sb.pop_front();
              eng_ready = 1'b1;
              stall_cnt = 0;
              rx = cur.x + 9'(cur.nib[2]) - 9'(cur.nib[3]);
              ry = cur.y + 9'(cur.nib[0]) - 9'(cur.nib[1]);
              rd = cur.nib[2] ? 2'd1 : cur.nib[3] ? 2'd3 : cur.nib[1] ? 2'd2 : 2'd0;
              if (!never_respond) begin
                busy = 1'b1;
                lat_cnt = latency - 1;
                exp_x[cur.id] = rx; exp_y[cur.id] = ry; exp_d[cur.id] = rd;
              end
            end
          end
        end
      end
    end
  end

  task automatic run_frame(input int i);
    row_t r;
    int   fd_at, limit;
    r = rows[i];
    game_state = r.gs; num_players = r.np; btn = r.btn;
    stall_cycles = r.stall; latency = r.lat;
    if (r.gs == GS_PLAY) push_reqs(r.np, r.btn);
    if (r.gs == GS_START) begin
      exp_x = SPAWN_X;
      exp_y = SPAWN_Y;
    end
    vsync = 1'b1;
    fd_at = 0;
    limit = (r.exp_fd == 0) ? 20 : 80;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (r.drop && eng_valid) game_state = GS_MENU;
      if (frame_done) begin
        fd_at = k;
        break;
      end
    end
    check($sformatf("row%0d_fd_cycle", i), fd_at, r.exp_fd);
    if (fd_at != 0) begin
      @(negedge clk);
      check($sformatf("row%0d_fd_pulse", i), frame_done, 1'b0);
    end
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    check_positions($sformatf("row%0d", i));
  endtask

  initial begin : main
    bit found;
    int fd_count;
    rst = 1'b1; vsync = 1'b0; game_state = GS_PLAY; num_players = 2'd0; btn = 16'h0;
    exp_x = SPAWN_X; exp_y = SPAWN_Y; exp_d = '{default: 2'd0};

    // Frame-done cycle counts are measured from the negedge vsync rises.
    rows[0] = '{GS_PLAY,  2'd0, 16'h0000, 0, 2, 1'b0, 5};
    rows[1] = '{GS_PLAY,  2'd3, 16'h0000, 0, 2, 1'b0, 8};
    rows[2] = '{GS_PLAY,  2'd1, 16'h0004, 0, 2, 1'b0, 9};
    rows[3] = '{GS_PLAY,  2'd3, 16'h1248, 5, 2, 1'b0, 40};
    rows[4] = '{GS_PLAY,  2'd2, 16'h3F0F, 0, 1, 1'b0, 11};
    rows[5] = '{GS_PLAY,  2'd1, 16'h0048, 0, 2, 1'b1, 12};
    rows[6] = '{GS_START, 2'd3, 16'h4444, 0, 2, 1'b0, 0};
    rows[7] = '{GS_MENU,  2'd3, 16'h1111, 0, 2, 1'b0, 0};
    rows[8] = '{3'd5,     2'd3, 16'h2222, 0, 2, 1'b0, 0};
    rows[9] = '{GS_PLAY,  2'd0, 16'h0001, 1, 3, 1'b0, 10};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_eng", {eng_valid, eng_id, eng_x, eng_y, eng_btn}, 64'd0);
    check("rst_flags", {frame_done, overrun, timeout_err}, 3'b000);
    check_positions("rst");

    for (int i = 0; i < 10; i++) run_frame(i);
    check("overrun_pre", overrun, 1'b0);

    // Second vsync rise while slot 2 is busy: flagged, ignored, pass completes.
    game_state = GS_PLAY; num_players = 2'd3; btn = 16'h4444;
    stall_cycles = 0; latency = 6;
    push_reqs(2'd3, 16'h4444);
    vsync = 1'b1;
    found = 1'b0;
    fd_count = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (frame_done) fd_count++;
      if (eng_valid && eng_id == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("ovr_slot2_seen", found, 1'b1);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_done) fd_count++;
    end
    check("ovr_frames", fd_count, 1);
    check("ovr_flag", overrun, 1'b1);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    check_positions("ovr");

`ifdef PLAYER_SCHED_TIMEOUT_EN
    never_respond = 1'b1;
    num_players = 2'd1; btn = 16'h0044; stall_cycles = 0;
    push_reqs(2'd1, 16'h0044);
    vsync = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (eng_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("to_first_req", found, 1'b1);
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (j == 16) check("to_err_early", timeout_err, 1'b0);
      if (j == 17) begin
        check("to_err_set", timeout_err, 1'b1);
        check("to_next_req", {eng_valid, eng_id}, 3'b1_01);
      end
    end
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    check("to_frame_done", found, 1'b1);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    check_positions("to");
    never_respond = 1'b0;
`else
    check("timeout_err_tied", timeout_err, 1'b0);
`endif

    // Reset while a request is stalled: eng_valid drops at that edge.
    num_players = 2'd0; btn = 16'h0002; stall_cycles = 1000;
    push_reqs(2'd0, 16'h0002);
    vsync = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (eng_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("rmid_valid_before", found, 1'b1);
    rst = 1'b1;
    sb.delete();
    exp_x = SPAWN_X; exp_y = SPAWN_Y; exp_d = '{default: 2'd0};
    @(negedge clk);
    check("rmid_valid_dropped", eng_valid, 1'b0);
    check("rmid_flags", {overrun, timeout_err}, 2'b00);
    check_positions("rmid");
    rst = 1'b0; vsync = 1'b0; stall_cycles = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_sched.md
# player_sched

Per-frame scheduler that time-shares one `player_move` engine among up to four players. On each vsync frame start it walks the active player slots in order and issues one move request per slot that has a direction pressed. It commits each engine result into per-player position/direction registers, which feed the renderer and the network sync logic. It sits between the input/network layer and the single `player_move` instance.

## Interface
- `TIMEOUT` — default 1024 — cycles to wait for `eng_done` before abandoning a slot (used only with `PLAYER_SCHED_TIMEOUT_EN`).
- `clk_in`  in  1  system clock (65 MHz); everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `vsync`  in  1  raw vsync level; asynchronous to scheduling, so it is synchronised internally.
- `game_state`  in  3  0 = MENU, 1 = START, 2 = PLAY; other values are treated as MENU.
- `num_players`  in  2  active player count minus one (0..3).
- `btn`  in  16  {left,right,up,down} per player; player p occupies bits [4p+3:4p].
- `eng_valid`  out  1  request to the engine.
- `eng_ready`  in  1  engine accepts the request.
- `eng_id`  out  2  slot being moved.
- `eng_x`, `eng_y`  out  9 each  current position of the slot.
- `eng_btn`  out  4  direction bits of the slot.
- `eng_done`  in  1  one-cycle result strobe.
- `eng_new_x`, `eng_new_y`  in  9 each  engine result position.
- `eng_new_dir`  in  2  engine result direction.
- `player_x`, `player_y`  out  4×9 packed  per-slot positions.
- `player_dir`  out  4×2 packed  per-slot directions.
- `frame_done`  out  1  one-cycle pulse when a pass completes.
- `overrun`  out  1  sticky; a frame start arrived while a pass was busy.
- `timeout_err`  out  1  sticky; a slot was abandoned.

## Operation
- Reset values:
  - all outputs 0;
  - positions load the spawn table: slot0 (400,208), slot1 (112,208), slot2 (256,112), slot3 (256,304);
  - `player_dir` = 0;
  - FSM in IDLE.
- Frame start: 2-FF synchroniser on `vsync`, then rising-edge detect, giving a one-cycle `frame_start`.
- FSM states: IDLE, ISSUE, WAIT, COMMIT.
- IDLE:
  - on `frame_start` with `game_state`==PLAY: slot←0, go to ISSUE;
  - with `game_state`==START: reload the spawn table and stay in IDLE;
  - otherwise hold.
- ISSUE:
  - if the slot's `btn` nibble is 0, skip: 1 cycle, no request, then advance;
  - otherwise assert `eng_valid` and drive `eng_id/x/y/btn` stable; transfer happens on the cycle where `eng_valid`&&`eng_ready`, then go to WAIT.
- WAIT:
  - on `eng_done`, latch the results and go to COMMIT;
  - `eng_done` arriving outside WAIT is ignored.
- COMMIT: write `player_x/y/dir[slot]` for one cycle, then advance.
- Advance: if slot==`num_players`, pulse `frame_done` and return to IDLE; else slot+1, go to ISSUE.
- `frame_start` while not in IDLE: set `overrun` and ignore that frame. The pass in progress continues.
- `game_state` leaving PLAY mid-pass: the current pass completes normally. No new pass starts.
- `num_players` is sampled at pass start and held for the pass.
- Slots above `num_players` are never touched and keep their values.
- Reset mid-pass:
  - `eng_valid` deasserts at that edge;
  - positions return to the spawn table;
  - sticky flags clear.
- Sticky flags clear only on reset.

## Timing
- `frame_start` occurs 3 cycles after the `vsync` rise at `clk_in`.
- Active slot cost: 1 ISSUE cycle (plus `eng_ready` stall), then the engine latency, then 1 COMMIT cycle.
- Skipped slot cost: 1 cycle.
- `player_*` registers update on the clock edge after the COMMIT cycle begins, and are visible one cycle after `eng_done`+1.
- `frame_done` is asserted in the cycle after the last COMMIT or skip.
- All outputs are registered.

## Configuration
- `PLAYER_SCHED_TIMEOUT_EN` defined:
  - a counter runs in WAIT;
  - after `TIMEOUT` cycles without `eng_done`, the slot is abandoned: its position is unchanged and `timeout_err` is set;
  - the FSM then advances.
- Undefined: WAIT blocks indefinitely and `timeout_err` is tied to 0.

## Structure
- `overcooked_pkg` holds:
  - the game-state constants (MENU/START/PLAY);
  - the spawn X/Y constant arrays;
  - the 9-bit coordinate typedef;
  - the scheduler state enum.
- One sub-module: `sync_edge`, a 2-FF synchroniser plus rising-edge pulse, used for `vsync`.

## Test plan
- Reset with `game_state`=2, then one frame with no buttons: no `eng_valid`; `frame_done` arrives 1+(`num_players`+1) cycles after `frame_start`; positions equal the spawn table.
- `num_players`=1, slot0 right pressed, engine returns (401,208,dir 1) after 2 cycles with `eng_ready`=1: `player_x[0]`=401, `player_dir[0]`=1, slot1 unchanged.
- `num_players`=3, all slots pressed, `eng_ready` held low 5 cycles per slot: `eng_id` sequence 0,1,2,3; `eng_x/y` stable during each stall; 4 commits.
- Second `vsync` rise while slot2 is in WAIT: `overrun`=1, the pass finishes, and no extra pass runs.
- `PLAYER_SCHED_TIMEOUT_EN`, `TIMEOUT`=16, engine never responds: `timeout_err`=1 after 16 WAIT cycles, position unchanged, next slot issued.
- `game_state`=1 at a frame start after movement: positions reload to (400,208)/(112,208)/(256,112)/(256,304). A reset asserted during WAIT drops `eng_valid` on the same edge.
